// File: rtl/nco_period_meter_if.sv
// nco_period_meter sample/control/result bundle.
// pp_out exists only when NCO_PERIOD_METER_AMP_EN is defined.
interface nco_period_meter_if #(
  parameter int CNT_W = 16
) ();
  logic [7:0]       sample_in;
  logic             sample_valid;
  logic             start;
  logic             busy;
  logic             period_valid;
  logic [CNT_W-1:0] period_out;
  logic             timeout;
`ifdef NCO_PERIOD_METER_AMP_EN
  logic [7:0]       pp_out;

  modport master (
    output sample_in, sample_valid, start,
    input  busy, period_valid, period_out, timeout, pp_out
  );

  modport slave (
    input  sample_in, sample_valid, start,
    output busy, period_valid, period_out, timeout, pp_out
  );
`else
  modport master (
    output sample_in, sample_valid, start,
    input  busy, period_valid, period_out, timeout
  );

  modport slave (
    input  sample_in, sample_valid, start,
    output busy, period_valid, period_out, timeout
  );
`endif
endinterface

// File: rtl/nco_period_meter.sv
// Tone period meter: averaged rising mid-crossing spacing, in samples.
// Optional NCO_PERIOD_METER_AMP_EN adds peak-to-peak amplitude readout.
module nco_period_meter #(
  parameter int CNT_W    = 16,
  parameter int AVG_LOG2 = 2,
  parameter int MID      = 127,
  parameter int HYST     = 8
) (
  input logic               clk,
  input logic               rst,
  nco_period_meter_if.slave bus
);

  localparam int XW = AVG_LOG2 + 1;
  localparam logic [XW-1:0] NXC = XW'(1 << AVG_LOG2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [7:0] HI_TH = 8'(MID + HYST);
  localparam logic [7:0] LO_TH = 8'(MID - HYST);

  typedef enum logic [1:0] {
    IDLE, ARM, MEASURE, DONE
  } state_t;

  state_t           state, state_n;
  logic             pol, pol_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [XW-1:0]    xcnt, xcnt_n, xcnt_inc;
  logic [CNT_W-1:0] per, per_n;
  logic             to, to_n;
  logic             acc, hi, lo, rise;

  // polarity tracker and crossing detect on accepted samples
  always_comb begin
    acc   = bus.sample_valid;
    hi    = bus.sample_in >= HI_TH;
    lo    = bus.sample_in <= LO_TH;
    rise  = acc && !pol && hi;
    pol_n = pol;
    unique case (1'b1)
      (acc && hi): pol_n = 1'b1;
      (acc && lo): pol_n = 1'b0;
      default:     pol_n = pol;
    endcase
  end

  // measurement FSM next state, counters and result latch
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    xcnt_n   = xcnt;
    per_n    = per;
    to_n     = to;
    cnt_inc  = cnt + CNT_W'(1);
    xcnt_inc = xcnt + XW'(1);
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = ARM;
          cnt_n   = '0;
        end
      end
      ARM: begin
        if (acc) begin
          if (rise) begin
            state_n = MEASURE;
            cnt_n   = '0;
            xcnt_n  = '0;
          end else begin
            cnt_n = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state_n = DONE;
              per_n   = CNT_MAX;
              to_n    = 1'b1;
            end
          end
        end
      end
      MEASURE: begin
        if (acc) begin
          cnt_n = cnt_inc;
          if (rise) xcnt_n = xcnt_inc;
          if (rise && xcnt_inc == NXC) begin
            state_n = DONE;
            per_n   = cnt_inc >> AVG_LOG2;
            to_n    = 1'b0;
          end else if (cnt_inc == CNT_MAX) begin
            state_n = DONE;
            per_n   = CNT_MAX;
            to_n    = 1'b1;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // state and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pol   <= 1'b0;
      cnt   <= '0;
      xcnt  <= '0;
      per   <= '0;
      to    <= 1'b0;
    end else begin
      state <= state_n;
      pol   <= pol_n;
      cnt   <= cnt_n;
      xcnt  <= xcnt_n;
      per   <= per_n;
      to    <= to_n;
    end
  end

  assign bus.busy         = (state == ARM) || (state == MEASURE);
  assign bus.period_valid = (state == DONE);
  assign bus.period_out   = per;
  assign bus.timeout      = to;

`ifdef NCO_PERIOD_METER_AMP_EN
  logic [7:0] mn, mn_n, mx, mx_n, pp, pp_n;

  // min/max over measured samples; difference captured with the result
  always_comb begin
    mn_n = mn;
    mx_n = mx;
    pp_n = pp;
    if ((state == IDLE && bus.start) || (state == ARM && rise)) begin
      mn_n = 8'hFF;
      mx_n = 8'h00;
    end else if (state == MEASURE && acc) begin
      if (bus.sample_in < mn) mn_n = bus.sample_in;
      if (bus.sample_in > mx) mx_n = bus.sample_in;
    end
    if (state_n == DONE && state != DONE)
      pp_n = (mx_n >= mn_n) ? mx_n - mn_n : 8'h00;
  end

  // amplitude registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mn <= 8'hFF;
      mx <= 8'h00;
      pp <= 8'h00;
    end else begin
      mn <= mn_n;
      mx <= mx_n;
      pp <= pp_n;
    end
  end

  assign bus.pp_out = pp;
`endif

endmodule
